sha1_block_feeder: RTL

SHA1_BLOCK_FEEDER -- requirements
Module: sha1_block_feeder

---
 rtl/sha1_pkg.sv | 33 +++
 rtl/sha1_block_feeder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sha1_pkg.sv
// Shared definitions for the SHA-1 block feeder: FSM encoding, core register
// map defaults and poll timeout default.
package sha1_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    GUARD,
    POLL,
    READ,
    OUT,
    FAULT
  } state_t;

  // Register map of the attached sha1 core.
  localparam logic [7:0]  SHA1_ADDR_CTRL    = 8'h08;
  localparam logic [7:0]  SHA1_ADDR_STATUS  = 8'h09;
  localparam logic [7:0]  SHA1_ADDR_BLOCK0  = 8'h10;
  localparam logic [7:0]  SHA1_ADDR_DIGEST0 = 8'h20;
  localparam logic [15:0] SHA1_TIMEOUT      = 16'd1023;

  // Idle cycles after the control write so the core's ready bit can fall.
  localparam logic [15:0] GUARD_LAST  = 16'd1;
  // Index of the last digest word read back.
  localparam logic [15:0] DIGEST_LAST = 16'd4;

  // Address of word idx in a register window starting at base.
  function automatic logic [7:0] word_addr(input logic [7:0] base, input logic [3:0] idx);
    return base + {4'b0000, idx};
  endfunction

endpackage

// File: rtl/sha1_block_feeder.sv
// Streams 16 message words into a sha1 core, starts it, polls for completion,
// reads the 160-bit digest back and presents it on a valid/ready output.
//
// Handshakes: a transfer on s_* or d_* happens on a rising clk edge where
// valid and ready are both 1; valid holds its data until that edge, and ready
// may depend on state but never on the same port's valid.
module sha1_block_feeder
  import sha1_pkg::*;
#(
  parameter logic [7:0]  ADDR_CTRL    = SHA1_ADDR_CTRL,
  parameter logic [7:0]  ADDR_STATUS  = SHA1_ADDR_STATUS,
  parameter logic [7:0]  ADDR_BLOCK0  = SHA1_ADDR_BLOCK0,
  parameter logic [7:0]  ADDR_DIGEST0 = SHA1_ADDR_DIGEST0,
  parameter logic [15:0] TIMEOUT      = SHA1_TIMEOUT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [31:0]    s_data,
  input  logic           s_first,
  output logic           d_valid,
  input  logic           d_ready,
  output logic [159:0]   d_data,
  output logic [7:0]     core_addr,
  output logic [31:0]    core_wdata,
  input  logic [31:0]    core_rdata,
  output logic           core_cs,
  output logic           core_we,
  input  logic           core_error,
  output logic           err,
  output state_t         fsm_state
);

  state_t       state, state_next;
  logic [3:0]   word_cnt, word_cnt_next;
  logic [15:0]  cnt, cnt_next;        // shared by GUARD, POLL and READ
  logic         first_q, first_next;
  logic [159:0] d_data_next;
  logic         err_next;

  assign fsm_state = state;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      word_cnt <= 4'd0;
      cnt      <= 16'd0;
      first_q  <= 1'b0;
      d_data   <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      word_cnt <= word_cnt_next;
      cnt      <= cnt_next;
      first_q  <= first_next;
      d_data   <= d_data_next;
      err      <= err_next;
    end
  end

  // Next-state logic and core/stream strobes.
  always_comb begin
    state_next    = state;
    word_cnt_next = word_cnt;
    cnt_next      = cnt;
    first_next    = first_q;
    d_data_next   = d_data;
    err_next      = err;
    s_ready       = 1'b0;
    d_valid       = 1'b0;
    core_cs       = 1'b0;
    core_we       = 1'b0;
    core_addr     = '0;
    core_wdata    = '0;

    case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          core_cs       = 1'b1;
          core_we       = 1'b1;
          core_addr     = ADDR_BLOCK0;
          core_wdata    = s_data;
          first_next    = s_first;
          word_cnt_next = 4'd1;
          state_next    = LOAD;
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          core_cs    = 1'b1;
          core_we    = 1'b1;
          core_addr  = word_addr(ADDR_BLOCK0, word_cnt);
          core_wdata = s_data;
          if (word_cnt == 4'd15) begin
            word_cnt_next = 4'd0;
            state_next    = START;
          end else begin
            word_cnt_next = word_cnt + 4'd1;
          end
        end
      end
      START: begin
        core_cs    = 1'b1;
        core_we    = 1'b1;
        core_addr  = ADDR_CTRL;
        core_wdata = first_q ? 32'h0000_0001 : 32'h0000_0002;
        cnt_next   = 16'd0;
        state_next = GUARD;
      end
      GUARD: begin
        if (cnt == GUARD_LAST) begin
          cnt_next   = 16'd0;
          state_next = POLL;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      POLL: begin
        core_cs   = 1'b1;
        core_addr = ADDR_STATUS;
        if (core_rdata[1]) begin
          cnt_next   = 16'd0;
          state_next = READ;
        end else if (cnt == TIMEOUT - 16'd1) begin
          err_next   = 1'b1;
          state_next = FAULT;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      READ: begin
        core_cs   = 1'b1;
        core_addr = word_addr(ADDR_DIGEST0, cnt[3:0]);
        // Digest word 0 (H0) lands in the top 32 bits.
        for (int i = 0; i < 5; i++) begin
          if (cnt[2:0] == 3'(i)) d_data_next[159 - 32*i -: 32] = core_rdata;
        end
        if (cnt == DIGEST_LAST) begin
          cnt_next   = 16'd0;
          state_next = OUT;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      OUT: begin
        d_valid = 1'b1;
        if (d_ready) state_next = IDLE;
      end
      FAULT: begin
        // Parked until reset; every strobe stays at its default of 0.
      end
      default: state_next = FAULT;
    endcase

    // A core error outside IDLE aborts the block for good.
    if (state != IDLE && state != FAULT && core_error) begin
      err_next   = 1'b1;
      state_next = FAULT;
    end

    // No core access may escape while reset is held.
    if (reset) begin
      core_cs    = 1'b0;
      core_we    = 1'b0;
      core_addr  = '0;
      core_wdata = '0;
    end
  end

endmodule
